// File: rtl/instr_encoder.sv
// Sequential MIPS instruction encoder and program loader: accepts symbolic
// instructions over valid/ready and writes encoded words to consecutive imem addresses.
module instr_encoder #(
  parameter int          ADDR_W    = 8,
  parameter int unsigned BASE_ADDR = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              in_last,
  input  logic [3:0]        op_sel,
  input  logic [4:0]        rs,
  input  logic [4:0]        rt,
  input  logic [4:0]        rd,
  input  logic [15:0]       imm,
  input  logic [25:0]       target,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [31:0]       imem_wdata,
  output logic              busy,
  output logic              done,
  output logic              full,
  output logic              err,
  output logic [ADDR_W:0]   count
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ACCEPT,
    S_WRITE,
    S_DONE
  } state_t;

  localparam logic [ADDR_W-1:0] PTR_BASE = ADDR_W'(BASE_ADDR);
  localparam logic [ADDR_W-1:0] PTR_MAX  = '1;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] ptr_q, ptr_d;
  logic [ADDR_W:0]   count_q, count_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [31:0]       wdata_q, wdata_d;
  logic              last_q, last_d;
  logic              err_q, err_d;
  logic              full_q, full_d;
  logic              in_ready_q, in_ready_d;
  logic              we_q, we_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;

  logic [31:0]       enc_word;
  logic              enc_legal;

  // Mnemonic to machine word; fields are packed verbatim without range checks.
  always_comb begin
    enc_word  = 32'h0000_0000;
    enc_legal = 1'b1;
    case (op_sel)
      4'd0:    enc_word = {6'h00, rs, rt, rd, 5'd0, 6'h20};
      4'd1:    enc_word = {6'h00, rs, rt, rd, 5'd0, 6'h22};
      4'd2:    enc_word = {6'h00, rs, rt, rd, 5'd0, 6'h24};
      4'd3:    enc_word = {6'h00, rs, rt, rd, 5'd0, 6'h25};
      4'd4:    enc_word = {6'h00, rs, rt, rd, 5'd0, 6'h2A};
      4'd5:    enc_word = {6'h23, rs, rt, imm};
      4'd6:    enc_word = {6'h2B, rs, rt, imm};
      4'd7:    enc_word = {6'h04, rs, rt, imm};
      4'd8:    enc_word = {6'h08, rs, rt, imm};
      4'd9:    enc_word = {6'h02, target};
      4'd10:   enc_word = {6'h0D, rs, rt, imm};
      4'd11:   enc_word = {6'h0C, rs, rt, imm};
      4'd12:   enc_word = {6'h0A, rs, rt, imm};
      4'd13:   enc_word = 32'h0000_0000;
      default: enc_legal = 1'b0;
    endcase
  end

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    count_d = count_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    last_d  = last_q;
    err_d   = err_q;
    full_d  = full_q;
    case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          state_d = S_ACCEPT;
          ptr_d   = PTR_BASE;
          count_d = '0;
          err_d   = 1'b0;
          full_d  = 1'b0;
        end
      end
      S_ACCEPT: begin
        if (in_valid) begin
          if (enc_legal) begin
            state_d = S_WRITE;
            addr_d  = ptr_q;
            wdata_d = enc_word;
            last_d  = in_last;
          end else begin
            err_d = 1'b1;
            if (in_last) state_d = S_DONE;
          end
        end
      end
      S_WRITE: begin
        ptr_d   = ptr_q + ADDR_W'(1);
        count_d = count_q + (ADDR_W+1)'(1);
        // The top address is the last usable slot; stop rather than wrap.
        if (ptr_q == PTR_MAX) full_d = 1'b1;
        if (last_q || ptr_q == PTR_MAX) state_d = S_DONE;
        else                            state_d = S_ACCEPT;
      end
      default: state_d = S_IDLE;
    endcase

    in_ready_d = (state_d == S_ACCEPT);
    we_d       = (state_d == S_WRITE);
    busy_d     = (state_d == S_ACCEPT) || (state_d == S_WRITE);
    done_d     = (state_d == S_DONE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_IDLE;
      ptr_q      <= '0;
      count_q    <= '0;
      addr_q     <= '0;
      wdata_q    <= '0;
      last_q     <= 1'b0;
      err_q      <= 1'b0;
      full_q     <= 1'b0;
      in_ready_q <= 1'b0;
      we_q       <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      ptr_q      <= ptr_d;
      count_q    <= count_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      last_q     <= last_d;
      err_q      <= err_d;
      full_q     <= full_d;
      in_ready_q <= in_ready_d;
      we_q       <= we_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
    end
  end

  assign in_ready   = in_ready_q;
  assign imem_we    = we_q;
  assign imem_addr  = addr_q;
  assign imem_wdata = wdata_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign full       = full_q;
  assign err        = err_q;
  assign count      = count_q;

endmodule
